perf_counter_sampler: RTL and testbench
=======================================

Name: perf_counter_sampler

Overview:
Synthesizable, parametrised next-generation core performance profiler. Keeps cumulative saturating counters on-chip: global cycles, instructions retired, and a NUM_WARPS x NUM_EVENTS per-warp event matrix. Takes periodic and end-of-run snapshots into a one-deep shadow bank. Drains each snapshot serially over a valid/ready stream to the trace/MMIO sink, so counter observation no longer depends on a simulation-only call every cycle.

Parameters:
NUM_WARPS, 8, warps per core
NUM_EVENTS, 5, per-warp event types (0 decoded, 1 issued, 2 stallWAW, 3 stallWAR, 4 stallBusy, extensible)
COUNTER_WIDTH, 64, width of every counter and of out_data
INTERVAL_WIDTH, 32, width of sample-interval register
RETIRE_WIDTH, 4, width of per-cycle retire increment

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
enable  in  1  counting enable
evt_inc  in  NUM_WARPS*NUM_EVENTS  per-cycle event strobes, bit w*NUM_EVENTS+e
retire_inc  in  RETIRE_WIDTH  instructions retired this cycle
interval  in  INTERVAL_WIDTH  sample period in enabled cycles; 0 = periodic sampling off
finished  in  1  kernel finished (level)
out_valid  out  1  stream entry valid
out_ready  in  1  sink accepts entry
out_data  out  COUNTER_WIDTH  snapshot counter value
out_index  out  clog2(N)  entry index, N = 2+NUM_WARPS*NUM_EVENTS
out_last  out  1  final entry of a snapshot
out_sample_id  out  16  snapshot sequence number, wraps at 2^16
dropped_samples  out  16  periodic triggers lost while busy, saturating
done  out  1  final snapshot taken; counting frozen

Behaviour:
- Reset: all live counters, shadow bank, interval counter 0. Outputs: out_valid, out_data, out_index, out_last, out_sample_id, dropped_samples, done = 0. FSM enters IDLE. Reset mid-drain aborts the drain with no further out_valid.
- Counting active when enable && !done: cycles += 1, retired += retire_inc, counter[w][e] += evt_inc bit. All saturate at 2^COUNTER_WIDTH-1; they never wrap.
- Interval counter advances only when counting is active. Periodic trigger fires when interval != 0 && icnt+1 >= interval; icnt then <= 0. A lowered interval triggers immediately on the next active cycle.
- Final trigger: the rising edge of finished (registered previous value) sets done. Sets final_pending. Later finished toggles are ignored until reset.
- Snapshot value includes the trigger cycle's increments, i.e. next-state live values.
- Accept condition: state == IDLE, or state == DRAIN and the last-entry handshake completes this cycle.
- Periodic trigger when not acceptable: discarded; dropped_samples += 1, saturating.
- Final trigger is never dropped. It stays pending until accepted. Counters are frozen by done, so the captured values equal those at finish.
- Final and periodic triggers in the same cycle produce one snapshot, no drop.
- On accept: shadow <= live; out_sample_id increments (first snapshot shows id 0, then 1, ...); FSM -> DRAIN, index 0.
- DRAIN: out_valid=1. out_data = shadow[index]. Order: 0 cycles, 1 retired, 2+w*NUM_EVENTS+e per-warp (warp-major). out_last = (index == N-1).
- A handshake (valid && ready) advances index. out_data/out_index stay stable while !out_ready.
- After the last handshake: DRAIN -> IDLE, unless a new snapshot is accepted the same cycle, in which case stay in DRAIN at index 0 with no bubble.
- Live counters are cumulative and are never cleared by snapshots.

Test Plan:
- NUM_WARPS=2, NUM_EVENTS=2, interval=10, enable=1, evt_inc bit0 always, out_ready=1 -> snapshot at 10th cycle: cycles=10, counter[0][0]=10, others 0; 6 entries, out_last on index 5, sample_id 0, next at cycle 20 with id 1.
- interval=4, out_ready=0 held for 20 cycles -> one snapshot stalls (out_data stable), dropped_samples=4; releasing ready drains id 0 then resumes.
- Mid-drain finished rises at live cycles=37 -> no drop; after drain, second snapshot cycles=37, done=1; further enable cycles leave counters unchanged.
- COUNTER_WIDTH=4, retire_inc=7 for 5 cycles, finished -> retired snapshot = 15 (saturated), cycles=5.
- Last-entry handshake coincides with periodic trigger -> next snapshot index 0 the following cycle, out_valid never drops, dropped_samples unchanged.
- Reset asserted at index 3 of a drain -> next cycle out_valid=0, all outputs 0, fresh snapshot reports sample_id 0.

Source files
------------

// File: rtl/perf_counter_sampler.sv
// perf_counter_sampler: saturating perf counters with snapshot shadow bank drained over a valid/ready stream
module perf_counter_sampler #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_EVENTS = 5,
  parameter int COUNTER_WIDTH = 64,
  parameter int INTERVAL_WIDTH = 32,
  parameter int RETIRE_WIDTH = 4,
  localparam int N = 2 + NUM_WARPS * NUM_EVENTS,
  localparam int IXW = $clog2(N)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_WARPS*NUM_EVENTS-1:0] evt_inc,
  input  logic [RETIRE_WIDTH-1:0]         retire_inc,
  input  logic [INTERVAL_WIDTH-1:0]       interval,
  input  logic                            finished,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COUNTER_WIDTH-1:0]        out_data,
  output logic [IXW-1:0]                  out_index,
  output logic                            out_last,
  output logic [15:0]                     out_sample_id,
  output logic [15:0]                     dropped_samples,
  output logic                            done
);
  localparam int NE = NUM_WARPS * NUM_EVENTS;
  localparam logic [IXW-1:0] LAST = IXW'(N - 1);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [COUNTER_WIDTH-1:0] live_q [N], live_d [N], shadow_q [N], shadow_d [N];
  logic [COUNTER_WIDTH:0] ret_sum;
  logic [INTERVAL_WIDTH:0] inext;
  logic [INTERVAL_WIDTH-1:0] icnt_q, icnt_d;
  logic [IXW-1:0] idx_q, idx_d;
  logic [15:0] sid_q, sid_d, nid_q, nid_d, drop_q, drop_d;
  logic fin_q, done_q, done_d, fpend_q, fpend_d;
  logic active, per_trig, rise, fin_want, last_hs, accept_ok, accept;
  // live layout matches drain order: 0 cycles, 1 retired, 2+w*NUM_EVENTS+e events
  always_comb begin
    active = enable && !done_q;
    ret_sum = {1'b0, live_q[1]} + (COUNTER_WIDTH+1)'(retire_inc);
    live_d = live_q;
    if (active) begin
      live_d[0] = &live_q[0] ? live_q[0] : live_q[0] + COUNTER_WIDTH'(1);
      live_d[1] = ret_sum[COUNTER_WIDTH] ? '1 : ret_sum[COUNTER_WIDTH-1:0];
      for (int i = 0; i < NE; i++)
        live_d[i+2] = evt_inc[i] && !(&live_q[i+2]) ? live_q[i+2] + COUNTER_WIDTH'(1) : live_q[i+2];
    end
    inext = {1'b0, icnt_q} + (INTERVAL_WIDTH+1)'(1);
    per_trig = active && interval != '0 && inext >= {1'b0, interval};
    icnt_d = (!active || interval == '0) ? icnt_q : per_trig ? '0 : inext[INTERVAL_WIDTH-1:0];
    rise = finished && !fin_q && !done_q;
    fin_want = rise || fpend_q;
    last_hs = state_q == DRAIN && out_ready && idx_q == LAST;
    accept_ok = state_q == IDLE || last_hs;
    accept = (per_trig || fin_want) && accept_ok;
    fpend_d = fin_want && !accept;
    done_d = done_q || rise;
    // a periodic trigger folded into a pending final snapshot is not a drop
    drop_d = per_trig && !accept_ok && !fin_want && !(&drop_q) ? drop_q + 16'd1 : drop_q;
    shadow_d = shadow_q;
    if (accept) shadow_d = live_d;
    sid_d = accept ? nid_q : sid_q;
    nid_d = accept ? nid_q + 16'd1 : nid_q;
    state_d = accept ? DRAIN : last_hs ? IDLE : state_q;
    idx_d = (accept || last_hs) ? '0 : (state_q == DRAIN && out_ready) ? idx_q + IXW'(1) : idx_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      live_q <= '{default: '0};
      shadow_q <= '{default: '0};
      icnt_q <= '0;
      idx_q <= '0;
      sid_q <= '0;
      nid_q <= '0;
      drop_q <= '0;
      fin_q <= 1'b0;
      done_q <= 1'b0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q <= live_d;
      shadow_q <= shadow_d;
      icnt_q <= icnt_d;
      idx_q <= idx_d;
      sid_q <= sid_d;
      nid_q <= nid_d;
      drop_q <= drop_d;
      fin_q <= finished;
      done_q <= done_d;
      fpend_q <= fpend_d;
    end
  end
  assign out_valid = state_q == DRAIN;
  assign out_data = out_valid ? shadow_q[idx_q] : '0;
  assign out_index = idx_q;
  assign out_last = out_valid && idx_q == LAST;
  assign out_sample_id = sid_q;
  assign dropped_samples = drop_q;
  assign done = done_q;
endmodule

// File: tb/tb_perf_counter_sampler.sv
// tb_perf_counter_sampler: directed checks of snapshot, drain, drop, final and saturation behaviour
module tb_perf_counter_sampler;
  typedef logic [63:0] snap_t [6];
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, enable, finished, out_ready, out_valid, out_last, done;
  logic [3:0] evt_inc, retire_inc;
  logic [31:0] interval;
  logic [63:0] out_data;
  logic [2:0] out_index;
  logic [15:0] out_sample_id, dropped_samples;
  logic s_enable, s_finished, s_ready, s_valid, s_last, s_done;
  logic [3:0] s_evt, s_retire, s_data;
  logic [31:0] s_interval;
  logic [2:0] s_index;
  logic [15:0] s_sid, s_drop;
  int checks = 0;
  int errors = 0;
  perf_counter_sampler #(.NUM_WARPS(2), .NUM_EVENTS(2), .COUNTER_WIDTH(64)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .evt_inc(evt_inc), .retire_inc(retire_inc),
    .interval(interval), .finished(finished), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .out_sample_id(out_sample_id),
    .dropped_samples(dropped_samples), .done(done));
  perf_counter_sampler #(.NUM_WARPS(2), .NUM_EVENTS(2), .COUNTER_WIDTH(4)) u_sat (
    .clock(clock), .reset(reset), .enable(s_enable), .evt_inc(s_evt), .retire_inc(s_retire),
    .interval(s_interval), .finished(s_finished), .out_valid(s_valid), .out_ready(s_ready),
    .out_data(s_data), .out_index(s_index), .out_last(s_last), .out_sample_id(s_sid),
    .dropped_samples(s_drop), .done(s_done));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic quiet;
    {enable, finished, out_ready, evt_inc, retire_inc, interval} = '0;
    {s_enable, s_finished, s_ready, s_evt, s_retire, s_interval} = '0;
  endtask
  task automatic do_reset;
    quiet();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"}, out_data, 64'd0);
    check({tag, "_index"}, 64'(out_index), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_sid"}, 64'(out_sample_id), 64'd0);
    check({tag, "_drop"}, 64'(dropped_samples), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask
  // one entry is consumed per tick; fin_at raises finished before that entry's handshake edge
  task automatic drain_chk(input string tag, input snap_t exp, input logic [15:0] sid, input int fin_at);
    for (int e = 0; e < 6; e++) begin
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_index"}, 64'(out_index), 64'(e));
      check({tag, "_data"}, out_data, exp[e]);
      check({tag, "_last"}, 64'(out_last), 64'(e == 5));
      check({tag, "_sid"}, 64'(out_sample_id), 64'(sid));
      if (e == fin_at) finished = 1'b1;
      tick();
    end
  endtask
  initial begin
    do_reset();
    check_idle_zero("rst");
    // periodic sampling every 10 cycles, free-running sink
    enable = 1'b1; evt_inc = 4'b0001; interval = 32'd10; out_ready = 1'b1;
    repeat (9) tick();
    check("t1_pre_valid", 64'(out_valid), 64'd0);
    tick();
    drain_chk("t1_s0", '{64'd10, 64'd0, 64'd10, 64'd0, 64'd0, 64'd0}, 16'd0, -1);
    check("t1_gap_valid", 64'(out_valid), 64'd0);
    repeat (4) tick();
    drain_chk("t1_s1", '{64'd20, 64'd0, 64'd20, 64'd0, 64'd0, 64'd0}, 16'd1, -1);
    // stalled sink: triggers at 8,12,16,20 are dropped, data held
    do_reset();
    enable = 1'b1; evt_inc = 4'b0001; interval = 32'd4;
    repeat (10) tick();
    check("t2_stall_data", out_data, 64'd4);
    check("t2_stall_index", 64'(out_index), 64'd0);
    repeat (10) tick();
    check("t2_drop4", 64'(dropped_samples), 64'd4);
    check("t2_hold_data", out_data, 64'd4);
    out_ready = 1'b1;
    drain_chk("t2_s0", '{64'd4, 64'd0, 64'd4, 64'd0, 64'd0, 64'd0}, 16'd0, -1);
    check("t2_drop5", 64'(dropped_samples), 64'd5);
    repeat (2) tick();
    drain_chk("t2_s1", '{64'd28, 64'd0, 64'd28, 64'd0, 64'd0, 64'd0}, 16'd1, -1);
    // finished rises mid-drain at cycle 37; final snapshot follows with no bubble
    do_reset();
    enable = 1'b1; evt_inc = 4'b1001; retire_inc = 4'd2; interval = 32'd35; out_ready = 1'b1;
    repeat (35) tick();
    drain_chk("t3_s0", '{64'd35, 64'd70, 64'd35, 64'd0, 64'd0, 64'd35}, 16'd0, 1);
    check("t3_done", 64'(done), 64'd1);
    drain_chk("t3_fin", '{64'd37, 64'd74, 64'd37, 64'd0, 64'd0, 64'd37}, 16'd1, -1);
    finished = 1'b0;
    repeat (4) tick();
    finished = 1'b1;
    repeat (6) tick();
    check("t3_frozen_valid", 64'(out_valid), 64'd0);
    check("t3_frozen_done", 64'(done), 64'd1);
    check("t3_drop", 64'(dropped_samples), 64'd0);
    // 4-bit counters: retired saturates at 15
    do_reset();
    s_enable = 1'b1; s_retire = 4'd7; s_ready = 1'b1;
    repeat (4) tick();
    s_finished = 1'b1;
    tick();
    s_enable = 1'b0;
    for (int e = 0; e < 6; e++) begin
      check("t4_valid", 64'(s_valid), 64'd1);
      check("t4_index", 64'(s_index), 64'(e));
      check("t4_data", 64'(s_data), e == 0 ? 64'd5 : e == 1 ? 64'd15 : 64'd0);
      check("t4_last", 64'(s_last), 64'(e == 5));
      tick();
    end
    check("t4_done", 64'(s_done), 64'd1);
    check("t4_idle", 64'(s_valid), 64'd0);
    // last handshake coincides with a periodic trigger, then reset mid-drain
    do_reset();
    enable = 1'b1; evt_inc = 4'b0001; interval = 32'd6; out_ready = 1'b1;
    repeat (6) tick();
    drain_chk("t5_s0", '{64'd6, 64'd0, 64'd6, 64'd0, 64'd0, 64'd0}, 16'd0, -1);
    check("t5_b2b_valid", 64'(out_valid), 64'd1);
    check("t5_b2b_data", out_data, 64'd12);
    check("t5_b2b_sid", 64'(out_sample_id), 64'd1);
    check("t5_drop", 64'(dropped_samples), 64'd0);
    repeat (3) tick();
    check("t6_pre_index", 64'(out_index), 64'd3);
    reset = 1'b1;
    tick();
    check_idle_zero("t6_rst");
    reset = 1'b0;
    repeat (6) tick();
    drain_chk("t6_s0", '{64'd6, 64'd0, 64'd6, 64'd0, 64'd0, 64'd0}, 16'd0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
